thunderbolt_tsip_parser: RTL and testbench

Receives the byte stream from the Thunderbolt GPS receiver's UART and decodes TSIP framing. It extracts the Primary Timing Packet (ID 0x8F, subcode 0xAB) and presents the UTC date/time fields as stable 8-bit registers. Those registers feed the thunderbolt register file, which serves them on the memory read bus. Fields update atomically, and only from a complete, well-formed, range-checked packet.

---
 rtl/thunderbolt_tsip_parser_pkg.sv | 52 +++++
 rtl/thunderbolt_tsip_parser_destuffer.sv | 83 ++++++++
 rtl/thunderbolt_tsip_parser.sv | 152 +++++++++++++++
 tb/tb_thunderbolt_tsip_parser.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thunderbolt_tsip_parser_pkg.sv
// Shared TSIP protocol constants, FSM encodings and the time-field range check
// for the Thunderbolt Primary Timing Packet decoder.
package thunderbolt_tsip_parser_pkg;

    localparam logic [7:0] DLE                = 8'h10;
    localparam logic [7:0] ETX                = 8'h03;
    localparam logic [7:0] ID_PRIMARY_TIMING  = 8'h8F;
    localparam logic [7:0] SUB_PRIMARY_TIMING = 8'hAB;
    localparam logic [4:0] BODY_LEN           = 5'd17;

    localparam logic [4:0] OFS_SECONDS = 5'd10;
    localparam logic [4:0] OFS_MINUTES = 5'd11;
    localparam logic [4:0] OFS_HOURS   = 5'd12;
    localparam logic [4:0] OFS_DAY     = 5'd13;
    localparam logic [4:0] OFS_MONTH   = 5'd14;
    localparam logic [4:0] OFS_YEAR_H  = 5'd15;
    localparam logic [4:0] OFS_YEAR_L  = 5'd16;

    typedef enum logic [1:0] {
        DS_HUNT      = 2'd0,
        DS_GOT_DLE   = 2'd1,
        DS_FRAME     = 2'd2,
        DS_FRAME_DLE = 2'd3
    } ds_state_e;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_BODY = 2'd1,
        CAP_SKIP = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic [7:0] year_h;
        logic [7:0] year_l;
        logic [7:0] month;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] minutes;
        logic [7:0] seconds;
    } tsip_time_t;

    function automatic logic time_in_range(input logic [7:0] month,
                                           input logic [7:0] day,
                                           input logic [7:0] hour,
                                           input logic [7:0] minutes,
                                           input logic [7:0] seconds);
        return (month >= 8'd1) && (month <= 8'd12) &&
               (day >= 8'd1) && (day <= 8'd31) &&
               (hour <= 8'd23) && (minutes <= 8'd59) && (seconds <= 8'd60);
    endfunction

endpackage

// File: rtl/thunderbolt_tsip_parser_destuffer.sv
// TSIP link layer: finds frame starts, collapses DLE pairs and reports ETX.
// Strobes are combinational on the accepted byte so the capture stage can register its outputs.
module thunderbolt_tsip_parser_destuffer
    import thunderbolt_tsip_parser_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic       o_byte_vld,
    output logic [7:0] o_byte,
    output logic       o_start,
    output logic       o_end,
    output logic       o_abort
);

    ds_state_e state_q, state_d;

    // The byte is the data in every strobe: a de-stuffed DLE or a frame ID.
    assign o_byte = i_rx_data;

    // Link-layer state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= DS_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode for one received byte.
    always_comb begin
        state_d    = state_q;
        o_byte_vld = 1'b0;
        o_start    = 1'b0;
        o_end      = 1'b0;
        o_abort    = 1'b0;
        if (i_rx_valid) begin
            case (state_q)
                DS_HUNT: begin
                    if (i_rx_data == DLE) begin
                        state_d = DS_GOT_DLE;
                    end else begin
                        state_d = DS_HUNT;
                    end
                end
                DS_GOT_DLE: begin
                    if ((i_rx_data == ETX) || (i_rx_data == DLE)) begin
                        state_d = DS_HUNT;
                    end else begin
                        o_start = 1'b1;
                        state_d = DS_FRAME;
                    end
                end
                DS_FRAME: begin
                    if (i_rx_data == DLE) begin
                        state_d = DS_FRAME_DLE;
                    end else begin
                        o_byte_vld = 1'b1;
                    end
                end
                DS_FRAME_DLE: begin
                    if (i_rx_data == DLE) begin
                        o_byte_vld = 1'b1;
                        state_d    = DS_FRAME;
                    end else if (i_rx_data == ETX) begin
                        o_end   = 1'b1;
                        state_d = DS_HUNT;
                    end else begin
                        // A lone DLE followed by anything else opens a new frame with this ID.
                        o_abort = 1'b1;
                        o_start = 1'b1;
                        state_d = DS_FRAME;
                    end
                end
                default: state_d = DS_HUNT;
            endcase
        end else begin
            state_d = state_q;
        end
    end

endmodule

// File: rtl/thunderbolt_tsip_parser.sv
// Thunderbolt TSIP decoder: captures Primary Timing Packet (0x8F/0xAB) UTC fields
// and commits them atomically only from a complete, range-checked frame.
module thunderbolt_tsip_parser
    import thunderbolt_tsip_parser_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [7:0] o_thunder_year_h,
    output logic [7:0] o_thunder_year_l,
    output logic [7:0] o_thunder_month,
    output logic [7:0] o_thunder_day,
    output logic [7:0] o_thunder_hour,
    output logic [7:0] o_thunder_minutes,
    output logic [7:0] o_thunder_seconds,
    output logic       o_time_valid,
    output logic       o_pkt_err,
    output logic [7:0] o_err_cnt
);

    logic       ds_byte_vld_s, ds_start_s, ds_end_s, ds_abort_s;
    logic [7:0] ds_byte_s;
    logic       commit_ok_s;

    cap_state_e cap_q, cap_d;
    logic [4:0] idx_q, idx_d;
    logic [7:0] sub_q, sub_d;
    tsip_time_t fld_q, fld_d;
    tsip_time_t time_q, time_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;

    thunderbolt_tsip_parser_destuffer u_destuffer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_byte_vld (ds_byte_vld_s),
        .o_byte     (ds_byte_s),
        .o_start    (ds_start_s),
        .o_end      (ds_end_s),
        .o_abort    (ds_abort_s)
    );

    assign commit_ok_s = (idx_q == BODY_LEN) && (sub_q == SUB_PRIMARY_TIMING) &&
                         time_in_range(fld_q.month, fld_q.day, fld_q.hour,
                                       fld_q.minutes, fld_q.seconds);

    // Capture FSM: stores body bytes into the shadow and runs the commit check at ETX.
    always_comb begin
        cap_d   = cap_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        fld_d   = fld_q;
        time_d  = time_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (ds_start_s) begin
            // A new ID after a lone DLE is only an error if a timing packet was in progress.
            err_d = ds_abort_s && (cap_q == CAP_BODY);
            idx_d = 5'd0;
            cap_d = (ds_byte_s == ID_PRIMARY_TIMING) ? CAP_BODY : CAP_SKIP;
        end else begin
            case (cap_q)
                CAP_BODY: begin
                    if (ds_byte_vld_s) begin
                        if ((idx_q == 5'd0) && (ds_byte_s != SUB_PRIMARY_TIMING)) begin
                            cap_d = CAP_SKIP;
                        end else if (idx_q == BODY_LEN) begin
                            err_d = 1'b1;
                            cap_d = CAP_SKIP;
                        end else begin
                            idx_d = idx_q + 5'd1;
                            case (idx_q)
                                5'd0:        sub_d         = ds_byte_s;
                                OFS_SECONDS: fld_d.seconds = ds_byte_s;
                                OFS_MINUTES: fld_d.minutes = ds_byte_s;
                                OFS_HOURS:   fld_d.hour    = ds_byte_s;
                                OFS_DAY:     fld_d.day     = ds_byte_s;
                                OFS_MONTH:   fld_d.month   = ds_byte_s;
                                OFS_YEAR_H:  fld_d.year_h  = ds_byte_s;
                                OFS_YEAR_L:  fld_d.year_l  = ds_byte_s;
                                default:     sub_d         = sub_q;
                            endcase
                        end
                    end else if (ds_end_s) begin
                        cap_d = CAP_IDLE;
                        if (commit_ok_s) begin
                            time_d  = fld_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        cap_d = CAP_BODY;
                    end
                end
                CAP_SKIP: begin
                    if (ds_end_s) begin
                        cap_d = CAP_IDLE;
                    end else begin
                        cap_d = CAP_SKIP;
                    end
                end
                CAP_IDLE: cap_d = CAP_IDLE;
                default:  cap_d = CAP_IDLE;
            endcase
        end
        if (err_d && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Capture state, shadow and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_q   <= CAP_IDLE;
            idx_q   <= 5'd0;
            sub_q   <= 8'h00;
            fld_q   <= tsip_time_t'(56'd0);
            time_q  <= tsip_time_t'(56'd0);
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            cap_q   <= cap_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            fld_q   <= fld_d;
            time_q  <= time_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_thunder_year_h  = time_q.year_h;
    assign o_thunder_year_l  = time_q.year_l;
    assign o_thunder_month   = time_q.month;
    assign o_thunder_day     = time_q.day;
    assign o_thunder_hour    = time_q.hour;
    assign o_thunder_minutes = time_q.minutes;
    assign o_thunder_seconds = time_q.seconds;
    assign o_time_valid      = valid_q;
    assign o_pkt_err         = err_q;
    assign o_err_cnt         = cnt_q;

endmodule

// File: tb/tb_thunderbolt_tsip_parser.sv
// Self-checking bench: frames are described logically, the expected outcome of each
// frame is derived from the TSIP rules, and a per-cycle compare checks every output.
module tb_thunderbolt_tsip_parser;
    typedef logic [7:0] u8;

    localparam int EV_NONE  = 0;
    localparam int EV_VALID = 1;
    localparam int EV_ERR   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] y_h, y_l, mon, day, hr, mins, secs, err_cnt;
    logic       time_valid, pkt_err;

    int          total = 0;
    int          bad   = 0;
    int          cur_evt = EV_NONE;
    int          s_evt   = EV_NONE;
    logic [55:0] cur_time = 56'd0;
    logic [55:0] s_time   = 56'd0;
    logic [55:0] m_time   = 56'd0;
    int          m_cnt    = 0;

    thunderbolt_tsip_parser dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_rx_data         (rx_data),
        .i_rx_valid        (rx_valid),
        .o_thunder_year_h  (y_h),
        .o_thunder_year_l  (y_l),
        .o_thunder_month   (mon),
        .o_thunder_day     (day),
        .o_thunder_hour    (hr),
        .o_thunder_minutes (mins),
        .o_thunder_seconds (secs),
        .o_time_valid      (time_valid),
        .o_pkt_err         (pkt_err),
        .o_err_cnt         (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expectation of the byte the DUT consumes on this edge.
    always @(posedge clk) begin
        s_evt  <= cur_evt;
        s_time <= cur_time;
    end

    // Reference model update and per-cycle comparison.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_time = 56'd0;
            m_cnt  = 0;
        end else begin
            if (s_evt == EV_VALID) m_time = s_time;
            if (s_evt == EV_ERR && m_cnt < 255) m_cnt = m_cnt + 1;
            check("time_valid", time_valid, s_evt == EV_VALID);
            check("pkt_err", pkt_err, s_evt == EV_ERR);
            check("time_regs", {secs, mins, hr, day, mon, y_h, y_l}, m_time);
            check("err_cnt", err_cnt, m_cnt);
        end
    end

    function automatic void mk_body(input u8 se, input u8 mi, input u8 ho, input u8 dy,
                                    input u8 mo, input u8 yh, input u8 yl, input bit rnd,
                                    output u8 body[$]);
        body = {};
        body.push_back(8'hAB);
        for (int i = 1; i <= 9; i++) begin
            if (rnd) body.push_back(($urandom_range(0, 3) == 0) ? 8'h10 : u8'($urandom_range(0, 255)));
            else     body.push_back(8'h00);
        end
        body.push_back(se); body.push_back(mi); body.push_back(ho); body.push_back(dy);
        body.push_back(mo); body.push_back(yh); body.push_back(yl);
    endfunction

    // Wire encoding of a frame plus the single outcome the TSIP rules give it.
    function automatic void build(input u8 id, input u8 body[$], output u8 raw[$],
                                  output int evt_pos, output int evt_kind, output logic [55:0] t);
        int last[$];
        bit ok;
        raw = {};
        raw.push_back(8'h10);
        raw.push_back(id);
        foreach (body[i]) begin
            raw.push_back(body[i]);
            if (body[i] == 8'h10) raw.push_back(8'h10);
            last.push_back(raw.size() - 1);
        end
        raw.push_back(8'h10);
        raw.push_back(8'h03);
        evt_pos  = -1;
        evt_kind = EV_NONE;
        t        = 56'd0;
        if (id == 8'h8F) begin
            if (body.size() == 0) begin
                evt_pos = raw.size() - 1; evt_kind = EV_ERR;
            end else if (body[0] == 8'hAB) begin
                if (body.size() > 17) begin
                    evt_pos = last[17]; evt_kind = EV_ERR;
                end else if (body.size() < 17) begin
                    evt_pos = raw.size() - 1; evt_kind = EV_ERR;
                end else begin
                    t = {body[10], body[11], body[12], body[13], body[14], body[15], body[16]};
                    ok = (int'(body[14]) >= 1) && (int'(body[14]) <= 12) &&
                         (int'(body[13]) >= 1) && (int'(body[13]) <= 31) &&
                         (int'(body[12]) <= 23) && (int'(body[11]) <= 59) && (int'(body[10]) <= 60);
                    evt_pos  = raw.size() - 1;
                    evt_kind = ok ? EV_VALID : EV_ERR;
                end
            end
        end
    endfunction

    task automatic send_raw(input u8 raw[$], input int evt_pos, input int evt_kind,
                            input logic [55:0] t, input int max_gap);
        foreach (raw[i]) begin
            int g;
            g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int k = 0; k < g; k++) begin
                @(posedge clk); #1;
                rx_valid = 1'b0; cur_evt = EV_NONE;
            end
            @(posedge clk); #1;
            rx_data  = raw[i];
            rx_valid = 1'b1;
            cur_evt  = (i == evt_pos) ? evt_kind : EV_NONE;
            cur_time = t;
        end
    endtask

    task automatic send_frame(input u8 id, input u8 body[$], input int max_gap);
        u8 raw[$]; int ep; int ek; logic [55:0] t;
        build(id, body, raw, ep, ek, t);
        send_raw(raw, ep, ek, t, max_gap);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            rx_valid = 1'b0; cur_evt = EV_NONE;
        end
    endtask

    task automatic rand_frame();
        u8 body[$]; u8 junk[$]; u8 id;
        u8 se, mi, ho, dy, mo, yh, yl;
        int kind, n;
        se = u8'($urandom_range(0, 60)); mi = u8'($urandom_range(0, 59));
        ho = u8'($urandom_range(0, 23)); dy = u8'($urandom_range(1, 31));
        mo = u8'($urandom_range(1, 12));
        yh = ($urandom_range(0, 7) == 0) ? 8'h10 : u8'($urandom_range(0, 255));
        yl = ($urandom_range(0, 7) == 0) ? 8'h10 : u8'($urandom_range(0, 255));
        kind = $urandom_range(0, 6);
        id = 8'h8F;
        if (kind == 3) begin
            case ($urandom_range(0, 4))
                0: mo = ($urandom_range(0, 1) == 0) ? 8'd0 : u8'($urandom_range(13, 255));
                1: dy = ($urandom_range(0, 1) == 0) ? 8'd0 : u8'($urandom_range(32, 255));
                2: ho = u8'($urandom_range(24, 255));
                3: mi = u8'($urandom_range(60, 255));
                default: se = u8'($urandom_range(61, 255));
            endcase
        end
        mk_body(se, mi, ho, dy, mo, yh, yl, 1'b1, body);
        if (kind == 4) begin
            n = $urandom_range(1, 20);
            if (n <= 17) begin
                for (int k = 0; k < n; k++) void'(body.pop_back());
            end else begin
                for (int k = 17; k < n; k++) body.push_back(u8'($urandom_range(0, 255)));
            end
        end else if (kind == 5) begin
            do body[0] = u8'($urandom_range(0, 255)); while (body[0] == 8'hAB);
        end else if (kind == 6) begin
            do id = u8'($urandom_range(0, 255)); while (id == 8'h8F || id == 8'h10 || id == 8'h03);
        end
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
            u8 j;
            do j = u8'($urandom_range(0, 255)); while (j == 8'h10);
            junk.push_back(j);
        end
        send_raw(junk, -1, EV_NONE, 56'd0, 1);
        send_frame(id, body, 2);
    endtask

    initial begin
        u8 body[$]; u8 raw[$]; u8 part[$];
        int ep, ek; logic [55:0] t;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk); #1;
        check("reset_year_h", y_h, 8'h00);
        check("reset_seconds", secs, 8'h00);
        check("reset_valid", time_valid, 1'b0);
        check("reset_err_cnt", err_cnt, 8'h00);
        rst_n = 1'b1;

        // Clean 2024-05-17 12:34:56 frame, pulse exactly at ETX+1.
        mk_body(8'h38, 8'h22, 8'h0C, 8'h11, 8'h05, 8'h07, 8'hE8, 1'b0, body);
        send_frame(8'h8F, body, 0);
        idle(1);
        check("valid_at_etx_plus1", time_valid, 1'b1);
        idle(1);
        check("valid_one_cycle", time_valid, 1'b0);
        check("clean_year_h", y_h, 8'h07);
        check("clean_year_l", y_l, 8'hE8);
        check("clean_month", mon, 8'h05);
        check("clean_day", day, 8'h11);
        check("clean_hour", hr, 8'h0C);
        check("clean_minutes", mins, 8'h22);
        check("clean_seconds", secs, 8'h38);
        check("clean_err_cnt", err_cnt, 8'h00);

        // Seconds 0x10 stuffed commits; the same byte unstuffed is an error.
        mk_body(8'h10, 8'h22, 8'h0C, 8'h11, 8'h05, 8'h07, 8'hE8, 1'b0, body);
        send_frame(8'h8F, body, 0);
        idle(2);
        check("stuffed_seconds", secs, 8'h10);
        build(8'h8F, body, raw, ep, ek, t);
        raw.delete(13);
        send_raw(raw, 13, EV_ERR, 56'd0, 0);
        idle(2);
        check("unstuffed_held_seconds", secs, 8'h10);
        check("unstuffed_err_cnt", err_cnt, 8'h01);

        // Wrong subcode and a foreign ID are silent; a following good frame commits.
        body[0] = 8'hAC;
        send_frame(8'h8F, body, 0);
        body = {8'h01, 8'h10, 8'h02, 8'h10, 8'h03};
        send_frame(8'h47, body, 0);
        mk_body(8'h3C, 8'h3B, 8'h17, 8'h1F, 8'h0C, 8'h07, 8'hE9, 1'b0, body);
        send_frame(8'h8F, body, 0);
        idle(2);
        check("after_skip_hour", hr, 8'h17);
        check("after_skip_err_cnt", err_cnt, 8'h01);

        // Range and length errors leave the time untouched.
        mk_body(8'h00, 8'h00, 8'h00, 8'h01, 8'h0D, 8'h07, 8'hE9, 1'b0, body);
        send_frame(8'h8F, body, 0);
        mk_body(8'h00, 8'h00, 8'h18, 8'h01, 8'h01, 8'h07, 8'hE9, 1'b0, body);
        send_frame(8'h8F, body, 0);
        void'(body.pop_back());
        send_frame(8'h8F, body, 0);
        body.push_back(8'h00); body.push_back(8'h00);
        send_frame(8'h8F, body, 0);
        idle(2);
        check("errors_err_cnt", err_cnt, 8'h05);
        check("errors_hour_held", hr, 8'h17);

        for (int f = 0; f < 300; f++) rand_frame();
        idle(3);

        // Reset at body byte 12 clears outputs; the frame tail is ignored.
        mk_body(8'h38, 8'h22, 8'h0C, 8'h11, 8'h05, 8'h07, 8'hE8, 1'b0, body);
        send_frame(8'h8F, body, 0);
        idle(2);
        build(8'h8F, body, raw, ep, ek, t);
        part = {};
        for (int i = 0; i < 14; i++) part.push_back(raw[i]);
        send_raw(part, -1, EV_NONE, 56'd0, 0);
        @(posedge clk); #1;
        rx_valid = 1'b0; cur_evt = EV_NONE;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_year_h", y_h, 8'h00);
        check("async_rst_month", mon, 8'h00);
        check("async_rst_seconds", secs, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        part = {};
        for (int i = 14; i < raw.size(); i++) part.push_back(raw[i]);
        send_raw(part, -1, EV_NONE, 56'd0, 0);
        idle(2);
        check("tail_ignored_day", day, 8'h00);
        mk_body(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h07, 8'hEE, 1'b0, body);
        send_frame(8'h8F, body, 0);
        idle(2);
        check("post_reset_year_l", y_l, 8'hEE);
        check("post_reset_day", day, 8'h01);

        // 300 short frames back-to-back saturate the error counter.
        raw = {8'h10, 8'h8F, 8'hAB, 8'h10, 8'h03};
        for (int f = 0; f < 300; f++) send_raw(raw, 4, EV_ERR, 56'd0, 0);
        idle(3);
        check("saturated_err_cnt", err_cnt, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
